// File: rtl/hazard_controller.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use stalls,
// taken-branch flushes, data-memory freeze with timeout trap, saturating perf counters.
module hazard_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             stall,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [15:0] TIMEOUT16 = MEM_TIMEOUT[15:0];

    state_t           state_q, state_d;
    logic [15:0]      wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic uses_rs1, uses_rs2, load_use;
    logic freeze, run_eval;

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (id_opcode)
            7'b0000011, 7'b0010011:             uses_rs1 = 1'b1;
            7'b0100011, 7'b0110011, 7'b1100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            default: ;
        endcase
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   ((uses_rs1 && (ex_rd == id_rs1)) || (uses_rs2 && (ex_rd == id_rs2)));
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        freeze     = 1'b0;
        run_eval   = 1'b0;
        stall      = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pipe_hold  = 1'b0;
        mem_err    = 1'b0;

        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        freeze     = 1'b1;
                        state_d    = MEM_WAIT;
                        wait_cnt_d = 16'd1;
                    end else begin
                        run_eval = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (!dmem_ready) begin
                        freeze = 1'b1;
                        if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT16)) begin
                            state_d = ERROR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + 16'd1;
                        end
                    end else begin
                        // Ready cycle: the access completes, so the normal RUN priorities apply.
                        run_eval   = 1'b1;
                        state_d    = RUN;
                        wait_cnt_d = 16'd0;
                    end
                end
                ERROR: begin
                    freeze  = 1'b1;
                    mem_err = 1'b1;
                end
                default: state_d = RUN;
            endcase

            if (freeze) begin
                pipe_hold  = 1'b1;
                pc_write   = 1'b0;
                ifid_write = 1'b0;
            end else if (run_eval) begin
                if (ex_branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    stall      = 1'b1;
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                end
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((stall || pipe_hold) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= 16'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: a table of single-cycle vectors plus multi-cycle
// memory-wait, timeout, saturation and reset sequences, checked through a scoreboard queue.
module tb_hazard_controller;

    logic       clk;
    logic       rst;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       ex_memread, ex_branch_taken, dmem_req, dmem_ready;

    logic        a_stall, a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_pipe_hold, a_mem_err;
    logic [31:0] a_stall_cycles, a_flush_count;
    logic        b_stall, b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_pipe_hold, b_mem_err;
    logic [3:0]  b_stall_cycles, b_flush_count;

    // u_a: MEM_TIMEOUT=8, 32-bit counters; u_b: MEM_TIMEOUT=4, 4-bit counters
    hazard_controller #(.MEM_TIMEOUT(8), .CNT_W(32)) u_a (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall(a_stall), .pc_write(a_pc_write), .ifid_write(a_ifid_write),
        .ifid_flush(a_ifid_flush), .idex_flush(a_idex_flush), .pipe_hold(a_pipe_hold),
        .mem_err(a_mem_err), .stall_cycles(a_stall_cycles), .flush_count(a_flush_count)
    );

    hazard_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall(b_stall), .pc_write(b_pc_write), .ifid_write(b_ifid_write),
        .ifid_flush(b_ifid_flush), .idex_flush(b_idex_flush), .pipe_hold(b_pipe_hold),
        .mem_err(b_mem_err), .stall_cycles(b_stall_cycles), .flush_count(b_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // control word order: {stall, pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, mem_err}
    localparam logic [6:0] C_NORM   = 7'b0110000;
    localparam logic [6:0] C_STALL  = 7'b1000000;
    localparam logic [6:0] C_FLUSH  = 7'b0111100;
    localparam logic [6:0] C_FREEZE = 7'b0000010;
    localparam logic [6:0] C_ERROR  = 7'b0000011;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_R  = 7'b0110011;
    localparam logic [6:0] OP_BR   = 7'b1100011, OP_IMM   = 7'b0010011, OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef struct {
        string      name;
        logic [6:0] op;
        logic [4:0] rs1, rs2, rd;
        logic       memrd, br, req, rdy;
        logic [6:0] exp;
        logic       exp_s, exp_f;
    } vec_t;

    typedef struct {
        string      name;
        logic       sel_b;
        logic [6:0] exp;
    } sb_t;

    sb_t  sb[$];
    vec_t tbl[13];
    int   n_checks = 0;
    int   n_err    = 0;

    function automatic vec_t mk(string nm, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic memrd, logic br, logic req, logic rdy,
                                logic [6:0] exp, logic exp_s, logic exp_f);
        vec_t v;
        v.name = nm; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.memrd = memrd; v.br = br; v.req = req; v.rdy = rdy;
        v.exp = exp; v.exp_s = exp_s; v.exp_f = exp_f;
        return v;
    endfunction

    function automatic logic [6:0] ctl_a();
        return {a_stall, a_pc_write, a_ifid_write, a_ifid_flush, a_idex_flush, a_pipe_hold, a_mem_err};
    endfunction

    function automatic logic [6:0] ctl_b();
        return {b_stall, b_pc_write, b_ifid_write, b_ifid_flush, b_idex_flush, b_pipe_hold, b_mem_err};
    endfunction

    always @(negedge clk) begin
        sb_t        e;
        logic [6:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = e.sel_b ? ctl_b() : ctl_a();
            n_checks++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: ctl got %b expected %b", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_ctl(input string nm, input logic sel_b, input logic [6:0] e);
        sb_t s;
        s.name = nm; s.sel_b = sel_b; s.exp = e;
        sb.push_back(s);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [6:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic memrd, input logic br,
                          input logic req, input logic rdy);
        id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_memread = memrd; ex_branch_taken = br; dmem_req = req; dmem_ready = rdy;
    endtask

    task automatic idle();
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        tbl[0]  = mk("lu_add_rs1",    OP_R,     5'd5, 5'd7, 5'd5, 1, 0, 0, 0, C_STALL,  1, 0);
        tbl[1]  = mk("no_haz_x0",     OP_R,     5'd0, 5'd0, 5'd0, 1, 0, 0, 0, C_NORM,   0, 0);
        tbl[2]  = mk("no_haz_addi",   OP_IMM,   5'd1, 5'd5, 5'd5, 1, 0, 0, 0, C_NORM,   0, 0);
        tbl[3]  = mk("br_beats_lu",   OP_R,     5'd5, 5'd7, 5'd5, 1, 1, 0, 0, C_FLUSH,  0, 1);
        tbl[4]  = mk("lu_store_rs2",  OP_STORE, 5'd1, 5'd5, 5'd5, 1, 0, 0, 0, C_STALL,  1, 0);
        tbl[5]  = mk("lu_load_rs1",   OP_LOAD,  5'd9, 5'd2, 5'd9, 1, 0, 0, 0, C_STALL,  1, 0);
        tbl[6]  = mk("no_memread",    OP_R,     5'd5, 5'd5, 5'd5, 0, 0, 0, 0, C_NORM,   0, 0);
        tbl[7]  = mk("lui_no_use",    OP_LUI,   5'd5, 5'd5, 5'd5, 1, 0, 0, 0, C_NORM,   0, 0);
        tbl[8]  = mk("lu_branch_rs2", OP_BR,    5'd1, 5'd3, 5'd3, 1, 0, 0, 0, C_STALL,  1, 0);
        tbl[9]  = mk("jal_no_use",    OP_JAL,   5'd3, 5'd3, 5'd3, 1, 0, 0, 0, C_NORM,   0, 0);
        tbl[10] = mk("br_alone",      OP_IMM,   5'd1, 5'd2, 5'd3, 0, 1, 0, 0, C_FLUSH,  0, 1);
        tbl[11] = mk("freeze_first",  OP_R,     5'd5, 5'd7, 5'd5, 1, 1, 1, 0, C_FREEZE, 1, 0);
        tbl[12] = mk("req_ready",     OP_IMM,   5'd1, 5'd2, 5'd3, 0, 0, 1, 1, C_NORM,   0, 0);

        // Reset: outputs quiescent regardless of inputs, counters stay at zero
        rst = 1'b1;
        set_in(OP_R, 5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        expect_ctl("rst_quiet_a", 1'b0, C_NORM);
        expect_ctl("rst_quiet_b", 1'b1, C_NORM);
        tick();
        @(negedge clk);
        chk("rst_stall_cnt", a_stall_cycles, 32'd0);
        chk("rst_flush_cnt", a_flush_count, 32'd0);
        tick();

        for (int i = 0; i < 13; i++) begin
            do_reset();
            set_in(tbl[i].op, tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                   tbl[i].memrd, tbl[i].br, tbl[i].req, tbl[i].rdy);
            expect_ctl(tbl[i].name, 1'b0, tbl[i].exp);
            tick();
            idle();
            @(negedge clk);
            chk({tbl[i].name, "_scnt"}, a_stall_cycles, {31'd0, tbl[i].exp_s});
            chk({tbl[i].name, "_fcnt"}, a_flush_count,  {31'd0, tbl[i].exp_f});
        end

        // Memory wait: three held cycles, then a ready cycle that also carries a taken branch
        do_reset();
        set_in(OP_R, 5'd5, 5'd7, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            expect_ctl("memwait_hold", 1'b0, C_FREEZE);
            tick();
        end
        set_in(OP_R, 5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_ctl("memwait_ready", 1'b0, C_FLUSH);
        tick();
        idle();
        expect_ctl("memwait_back_run", 1'b0, C_NORM);
        @(negedge clk);
        chk("memwait_scnt", a_stall_cycles, 32'd3);
        chk("memwait_fcnt", a_flush_count, 32'd1);
        tick();

        // Timeout: u_b (MEM_TIMEOUT=4) traps at T+5, u_a (8) still waiting
        do_reset();
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            expect_ctl("tmo_wait_b", 1'b1, C_FREEZE);
            tick();
        end
        expect_ctl("tmo_err_b", 1'b1, C_ERROR);
        expect_ctl("tmo_wait_a", 1'b0, C_FREEZE);
        tick();
        set_in(OP_R, 5'd5, 5'd7, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        expect_ctl("tmo_sticky_b", 1'b1, C_ERROR);
        expect_ctl("tmo_ready_a", 1'b0, C_FLUSH);
        tick();
        rst = 1'b1;
        expect_ctl("tmo_rst_b", 1'b1, C_NORM);
        tick();
        rst = 1'b0;
        idle();
        expect_ctl("tmo_cleared_b", 1'b1, C_NORM);
        tick();

        // Saturation: 20 frozen cycles saturate the 4-bit counter at 15
        do_reset();
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        @(negedge clk);
        chk("sat_b_scnt", {28'd0, b_stall_cycles}, 32'd15);
        chk("sat_a_scnt", a_stall_cycles, 32'd20);
        expect_ctl("sat_err_b", 1'b1, C_ERROR);
        tick();

        // Reset in the middle of MEM_WAIT returns to RUN with cleared counters
        do_reset();
        set_in(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        expect_ctl("midrst_run_a", 1'b0, C_NORM);
        expect_ctl("midrst_run_b", 1'b1, C_NORM);
        @(negedge clk);
        chk("midrst_scnt_a", a_stall_cycles, 32'd0);
        chk("midrst_scnt_b", {28'd0, b_stall_cycles}, 32'd0);
        tick();

        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline sequencing controller for the 5-stage RV32I core.
- Detects load-use hazards and drives the `stall` input of the decode control unit.
- Flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Freezes the whole pipeline while the data memory is not ready, with a timeout error trap and saturating stall/flush performance counters.

Parameters:
- MEM_TIMEOUT, 16, max consecutive MEM_WAIT cycles before ERROR; 0 disables the timeout. 16-bit range.
- CNT_W, 32, performance counter width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- id_opcode  in  7  opcode of the instruction in ID
- id_rs1  in  5  rs1 field of the instruction in ID
- id_rs2  in  5  rs2 field of the instruction in ID
- ex_rd  in  5  destination register of the instruction in EX
- ex_memread  in  1  instruction in EX is a load
- ex_branch_taken  in  1  branch in EX resolved taken
- dmem_req  in  1  MEM stage is accessing data memory this cycle
- dmem_ready  in  1  data memory completes the access this cycle
- stall  out  1  to the control unit: insert a bubble into ID/EX
- pc_write  out  1  PC register enable
- ifid_write  out  1  IF/ID register enable
- ifid_flush  out  1  clear IF/ID to NOP
- idex_flush  out  1  clear ID/EX to NOP
- pipe_hold  out  1  hold ID/EX, EX/MEM and MEM/WB
- mem_err  out  1  sticky memory-timeout error
- stall_cycles  out  CNT_W  cycles with stall or pipe_hold asserted
- flush_count  out  CNT_W  taken-branch flush events

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- States are RUN, MEM_WAIT and ERROR. State, wait_cnt (16-bit) and both counters are registered. Control outputs are combinational from state and inputs.
- Reset (rst=1 at a clk edge):
  - state <= RUN, wait_cnt <= 0, counters <= 0, mem_err <= 0.
  - While rst=1, outputs are forced quiescent: pc_write=1, ifid_write=1, all other control outputs 0.
- Register use, decoded from id_opcode:
  - uses_rs1 for opcodes 0000011, 0100011, 0110011, 1100011, 0010011.
  - uses_rs2 for opcodes 0100011, 0110011, 1100011.
- load_use = ex_memread & (ex_rd!=0) & ((uses_rs1 & ex_rd==id_rs1) | (uses_rs2 & ex_rd==id_rs2)).
- RUN, priority high to low:
  1. dmem_req & !dmem_ready (freeze): pipe_hold=1, pc_write=0, ifid_write=0, stall=0, no flush. Next state MEM_WAIT, wait_cnt <= 1.
  2. ex_branch_taken (flush): ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1, stall=0. The load-use condition is ignored because the instruction in ID is wrong-path.
  3. load_use: stall=1, pc_write=0, ifid_write=0 for exactly this cycle. The bubble resolves the hazard next cycle.
  4. Otherwise: pc_write=1, ifid_write=1, everything else 0.
- MEM_WAIT:
  - dmem_ready=0: outputs as freeze; branch and load-use are not evaluated.
    - If MEM_TIMEOUT!=0 and wait_cnt==MEM_TIMEOUT, next state ERROR.
    - Otherwise wait_cnt++.
  - dmem_ready=1: outputs evaluated exactly as RUN priorities 2–4. Freeze is not re-entered this cycle. Next state RUN, wait_cnt <= 0.
- ERROR:
  - Outputs as freeze, mem_err=1.
  - Stays in ERROR until rst; all inputs are ignored.
- Counters:
  - stall_cycles increments each cycle with (stall | pipe_hold).
  - flush_count increments each cycle with ifid_flush.
  - Both saturate at all-ones and do not count while rst=1.

Test Plan:
- Load-use: EX is `lw x5` (ex_memread=1, ex_rd=5); ID is `add x6,x5,x7` (opcode 0110011, rs1=5) -> stall=1, pc_write=0, ifid_write=0 for 1 cycle; stall_cycles=1.
- No false hazard:
  - ex_rd=0 with ID rs1=0 -> stall=0.
  - ex_rd=5 with ID `addi` (0010011) whose rs2 field is 5 -> stall=0, since addi does not use rs2.
- Branch flush beats load-use: ex_branch_taken=1 and load_use=1 in the same cycle -> ifid_flush=idex_flush=1, stall=0, pc_write=1; flush_count=1.
- Memory wait: dmem_req=1 with dmem_ready=0 for 3 cycles, then 1 (MEM_TIMEOUT=8) -> pipe_hold=1 for 3 cycles, then 0 on the ready cycle; state returns to RUN; stall_cycles=3.
- Timeout: MEM_TIMEOUT=4, dmem_req=1 raised in RUN at cycle T, dmem_ready held 0 -> MEM_WAIT from T+1, ERROR at T+5, mem_err=1 and pipe_hold=1 persist; rst pulse clears both.
- Saturation and reset: CNT_W=4, hold a freeze for 20 cycles -> stall_cycles stays at 15; synchronous rst mid-MEM_WAIT -> RUN, counters 0 next cycle.
